fib_loop_ctrl: RTL
==================

// Module: fib_loop_ctrl
// PURPOSE
//   Sequencer for the fib-style arithmetic loop datapath (x/y/i/j registers updated once per step
//   under a selector). Accepts a start request with an iteration bound, pulses datapath init,
//   issues exactly N step enables with a per-step selector, and reports done/err.
//   Owns the loop counter i; aborts early on a datapath overflow or an external abort.
// PARAMETERS
//   WIDTH     11  width of iteration bound and counter (matches datapath word)
//   SEL_MODE  0   0: dp_sel = sel_in pass-through; 1: dp_sel toggles internally, starting at 0
// PORTS
//   clk       in   1      clock, all logic rising-edge
//   rst       in   1      synchronous reset, active-high
//   start     in   1      request a new run; sampled only in IDLE
//   n_iter    in   WIDTH  number of steps; latched on accepted start
//   sel_in    in   1      external step selector (SEL_MODE=0)
//   abort     in   1      cancel the current run
//   dp_ovf    in   1      datapath overflow flag, valid in the cycle dp_step=1
//   dp_init   out  1      one-cycle pulse: datapath loads its initial values
//   dp_step   out  1      datapath performs one update this cycle
//   dp_sel    out  1      selector for this step; 0 when dp_step=0
//   i         out  WIDTH  steps completed in the current/last run
//   busy      out  1      high in INIT and RUN
//   done      out  1      one-cycle completion pulse
//   err       out  1      sticky: last run ended on dp_ovf
// BEHAVIOUR
//   Reset: state=IDLE, all outputs 0, latched limit=0, toggle=0. Reset mid-run drops to IDLE
//     with no done pulse.
//   FSM states: IDLE, INIT, RUN, DONE. The FSM is Moore except dp_sel (SEL_MODE=0).
//   IDLE: start=1 -> limit<=n_iter, i<=0, err<=0, toggle<=0, go INIT.
//   INIT (1 cycle): dp_init=1. limit==0 -> DONE, else -> RUN.
//   RUN: dp_step=1 every cycle, i<=i+1 each cycle. The step that completes i==limit ->
//     DONE, so exactly limit steps are issued. First dp_step is 2 cycles after start.
//     SEL_MODE=1: dp_sel=toggle, and toggle inverts after each step.
//   DONE (1 cycle): done=1, then IDLE. start in DONE is ignored.
//   dp_ovf=1 in a RUN cycle: that step counts (i increments), err<=1, go DONE.
//   abort=1 in INIT/RUN: go IDLE next cycle; i holds, no done, err unchanged.
//     abort in IDLE or DONE has no effect.
//   Priority in the same cycle: rst > abort > dp_ovf > terminal count.
//   start while busy is ignored; n_iter changes after acceptance have no effect.
//   i never wraps: max limit is 2^WIDTH-1, and RUN ends when i reaches limit.
//   i and err hold after DONE until the next accepted start.
//   busy = (state==INIT || state==RUN). done and busy are never high together.
// TESTING
//   1. start, n_iter=5, SEL_MODE=0, sel_in random -> dp_init at cycle+1; dp_step cycles+2..+6
//      with dp_sel==sel_in; done at +7; i=5; err=0.
//   2. n_iter=0 -> dp_init at +1, done at +2, no dp_step, i=0.
//   3. n_iter=8, dp_ovf=1 on 3rd step -> exactly 3 steps, i=3, done pulse, err=1;
//      the next start clears err.
//   4. n_iter=10, abort on 4th RUN cycle -> i=4, no done, busy low next cycle;
//      start in the cycle after the abort is accepted.
//   5. SEL_MODE=1, n_iter=4 -> dp_sel sequence 0,1,0,1. start pulses during RUN and DONE
//      -> ignored, no second run.
//   6. rst asserted mid-RUN (n_iter=2047) -> all outputs 0 next cycle;
//      run to completion gives i=2047 with no wrap.

Source files
------------

// File: rtl/fib_loop_ctrl.sv
// Sequencer for the fib-style loop datapath: init pulse, N step enables, done/err report.
// Latency: dp_init 1 cycle after accepted start, first dp_step 2 cycles after, done 1 cycle after last step.
// Backpressure: none; start is only sampled in IDLE, abort/dp_ovf cut a run short.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, n_iter     run request and its step count (latched on acceptance)
//   sel_in            external step selector, used when SEL_MODE=0
//   abort             cancels a run in INIT/RUN without a done pulse
//   dp_ovf            datapath overflow, meaningful while dp_step=1
//   dp_init/dp_step   datapath control strobes; dp_sel is the per-step selector
//   i                 steps completed in the current/last run
//   busy/done/err     status: running, completion pulse, last run hit overflow
module fib_loop_ctrl #(
    parameter int WIDTH    = 11,
    parameter int SEL_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n_iter,
    input  logic             sel_in,
    input  logic             abort,
    input  logic             dp_ovf,
    output logic             dp_init,
    output logic             dp_step,
    output logic             dp_sel,
    output logic [WIDTH-1:0] i,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INIT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;

    logic [1:0]       state;
    logic [WIDTH-1:0] limit;
    logic             toggle;
    logic [WIDTH-1:0] i_nxt;
    logic             sel_src;

    // i only advances in RUN, where it is strictly below limit, so this never wraps.
    assign i_nxt = i + CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            limit  <= CNT_ZERO;
            i      <= CNT_ZERO;
            err    <= 1'b0;
            toggle <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        limit  <= n_iter;
                        i      <= CNT_ZERO;
                        err    <= 1'b0;
                        toggle <= 1'b0;
                        state  <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (limit == CNT_ZERO) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // dp_step is already high this cycle, so the datapath has
                    // updated whatever the exit reason; the step always counts.
                    i      <= i_nxt;
                    toggle <= ~toggle;
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (dp_ovf) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else if (i_nxt == limit) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Everything is a pure state decode except dp_sel in pass-through mode.
    assign sel_src = (SEL_MODE != 0) ? toggle : sel_in;

    assign dp_init = (state == S_INIT);
    assign dp_step = (state == S_RUN);
    assign dp_sel  = dp_step & sel_src;
    assign busy    = (state == S_INIT) || (state == S_RUN);
    assign done    = (state == S_DONE);

endmodule
